frequency_window_controller: RTL and testbench
==============================================

Name: frequency_window_controller

Overview:
Sequences one FrequencyComparator instance through repeated measurement windows: clears it, enables it for a fixed number of clock ticks, freezes it, samples the f1/f2 accumulators and issues a decision: F1 tone, F2 tone or no signal. Results go downstream on a valid/ready handshake. Sits between the sample front end and the image-capture command decoder (FSK bit slicer path). Single-shot or continuous operation.

Parameters:
WINDOW_TICKS, 500000, comparator enable length per window in clock cycles (10 ms at 50 MHz); minimum 4.
MIN_TICKS, 125000, minimum accumulator value for a tone to count as present.
CLOCK, 50000000, system clock in Hz; documentation and derived constants only.

Ports:
clock  in  1  system clock, all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins a window when idle.
continuous  in  1  when high, the next window starts automatically after each result is accepted.
abort  in  1  returns to IDLE at the next edge; any window in flight is discarded.
cmp_enable  out  1  drives comparator enable.
cmp_clear  out  1  drives comparator clear.
f1_value  in  32  comparator F1 accumulator.
f2_value  in  32  comparator F2 accumulator.
result_valid  out  1  decision available.
result_ready  in  1  downstream accepts the decision.
result_code  out  2  00 none, 01 F1, 10 F2, 11 tie; stable while valid.
result_f1  out  32  captured f1_value for this result.
result_f2  out  32  captured f2_value for this result.
busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: state=IDLE; cmp_enable, cmp_clear, result_valid, busy = 0; result_code=00; result_f1/f2=0; window counter=0.
- The comparator honours clear only while enabled, so CLEAR drives cmp_enable=1 and cmp_clear=1 together.
- FSM, registered outputs:
  - IDLE: start=1 -> CLEAR.
  - CLEAR (1 cycle): enable=1, clear=1 -> MEASURE, counter=0.
  - MEASURE: enable=1, clear=0; counter increments each cycle; at counter==WINDOW_TICKS-1 -> SETTLE.
  - SETTLE (1 cycle): enable=0, so accumulators are frozen and stable -> EVALUATE.
  - EVALUATE (1 cycle): capture f1/f2 and compute code -> OUTPUT with result_valid=1.
  - OUTPUT: hold code and values until result_valid&&result_ready. On handshake: continuous=1 -> CLEAR, else -> IDLE.
- Latency: start to result_valid = WINDOW_TICKS+3 cycles. Continuous gap between windows = 1 cycle after the handshake.
- Decision, unsigned 32-bit compares:
  - f1<MIN_TICKS and f2<MIN_TICKS -> 00.
  - f1>f2 -> 01.
  - f2>f1 -> 10.
  - equal and at least MIN_TICKS -> 11.
- abort has priority over every transition. Next edge: IDLE, enable=0, clear=0, valid=0, captured values retained.
- start while busy: ignored. start and abort in the same cycle: abort wins.
- continuous dropped mid-window: the window completes and the result is delivered, then IDLE.
- Async reset mid-window: everything returns to reset values immediately. The comparator is not cleared until the next CLEAR state.
- result_ready while not valid: ignored.

Optional Feature:
FREQ_WINDOW_STATS_EN:
- Defined: adds outputs stat_f1_count, stat_f2_count, stat_none_count (16 bits each). Each increments on the handshake of a result with code 01, 10, or 00/11 respectively. Counters saturate at 0xFFFF and reset to 0.
- Undefined: no ports or logic for statistics; behaviour otherwise identical.

Decomposition:
- Package freq_detect_pkg: state encoding (IDLE, CLEAR, MEASURE, SETTLE, EVALUATE, OUTPUT), result code constants (RESULT_NONE, RESULT_F1, RESULT_F2, RESULT_TIE), window counter width as $clog2(WINDOW_TICKS).
- One sub-module: freq_decision, purely combinational: f1, f2, MIN_TICKS -> code. Reused by the bench scoreboard.

Test Plan:
- WINDOW_TICKS=100, MIN_TICKS=25, start pulse, comparator model gives f1=60, f2=10 -> cmp_enable high exactly 101 cycles (CLEAR+100), valid at cycle 103, code 01, result_f1=60.
- f1=10, f2=20 (both below 25) -> code 00. Then f1=f2=40 -> code 11.
- continuous=1, result_ready held low 50 cycles after valid -> code and values stable throughout, no new CLEAR. Ready high -> CLEAR on the next cycle.
- abort at MEASURE cycle 40 -> IDLE next edge, enable=0, no result_valid. Fresh start -> full 100-cycle window.
- Async reset asserted mid-OUTPUT between clock edges -> valid and busy drop immediately, no edge needed. start pulse during busy -> no effect on the running window.
- FREQ_WINDOW_STATS_EN defined, 3 F2 results accepted plus 1 abort -> stat_f2_count=3, others 0. Saturation checked by forcing the counter to 0xFFFE and accepting 2 results -> 0xFFFF.

Source files
------------

// File: rtl/freq_detect_pkg.sv
// Shared definitions for the frequency window controller: FSM state
// encoding, decision result codes, default parameter values and the
// window counter width helper.
package freq_detect_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        MEASURE  = 3'd2,
        SETTLE   = 3'd3,
        EVALUATE = 3'd4,
        OUTPUT   = 3'd5
    } state_t;

    localparam logic [1:0] RESULT_NONE = 2'b00;
    localparam logic [1:0] RESULT_F1   = 2'b01;
    localparam logic [1:0] RESULT_F2   = 2'b10;
    localparam logic [1:0] RESULT_TIE  = 2'b11;

    // 10 ms window at 50 MHz; a tone must fill a quarter of it to count.
    localparam int unsigned DEFAULT_WINDOW_TICKS = 500000;
    localparam int unsigned DEFAULT_MIN_TICKS    = 125000;
    localparam int unsigned DEFAULT_CLOCK_HZ     = 50000000;

    // Counter only has to reach ticks-1, so $clog2(ticks) bits suffice.
    function automatic int window_cnt_width(input int unsigned ticks);
        return (ticks <= 2) ? 1 : $clog2(ticks);
    endfunction

    localparam int WINDOW_CNT_W = window_cnt_width(DEFAULT_WINDOW_TICKS);

endpackage

// File: rtl/freq_decision.sv
// Purely combinational tone decision from the two frozen accumulators.
// Both below MIN_TICKS means no signal; otherwise the larger wins and an
// exact match is reported as a tie. All compares are unsigned 32-bit.
module freq_decision
    import freq_detect_pkg::*;
#(
    parameter int unsigned MIN_TICKS = DEFAULT_MIN_TICKS
) (
    input  logic [31:0] f1,
    input  logic [31:0] f2,
    output logic [1:0]  code
);

    localparam logic [31:0] MIN_V = 32'(MIN_TICKS);

    // Priority-ordered decision: absence check first, then magnitude.
    always_comb begin
        code = RESULT_NONE;
        if ((f1 < MIN_V) && (f2 < MIN_V)) begin
            code = RESULT_NONE;
        end else if (f1 > f2) begin
            code = RESULT_F1;
        end else if (f2 > f1) begin
            code = RESULT_F2;
        end else begin
            code = RESULT_TIE;
        end
    end

endmodule

// File: rtl/frequency_window_controller.sv
// Sequences a FrequencyComparator through measurement windows:
// CLEAR -> MEASURE (WINDOW_TICKS cycles) -> SETTLE -> EVALUATE -> OUTPUT.
// Optional statistics counters are built when FREQ_WINDOW_STATS_EN is defined.
//
// Result handshake: result_valid is raised when a decision is ready and
// stays high, with result_code/result_f1/result_f2 held constant, until the
// cycle in which result_ready is also high; that edge transfers the result.
// result_ready while result_valid is low has no effect. abort overrides the
// transfer (no result is delivered in an aborted cycle).
module frequency_window_controller
    import freq_detect_pkg::*;
#(
    parameter int unsigned WINDOW_TICKS = DEFAULT_WINDOW_TICKS,
    parameter int unsigned MIN_TICKS    = DEFAULT_MIN_TICKS,
    parameter int unsigned CLOCK        = DEFAULT_CLOCK_HZ
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    input  logic        abort,
    output logic        cmp_enable,
    output logic        cmp_clear,
    input  logic [31:0] f1_value,
    input  logic [31:0] f2_value,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [1:0]  result_code,
    output logic [31:0] result_f1,
    output logic [31:0] result_f2,
    output logic        busy,
`ifdef FREQ_WINDOW_STATS_EN
    output logic [15:0] stat_f1_count,
    output logic [15:0] stat_f2_count,
    output logic [15:0] stat_none_count,
`endif
    output state_t      state_dbg
);

    localparam int CNT_W = window_cnt_width(WINDOW_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_TICKS - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] win_cnt;
    logic [1:0]       dec_code;
    logic             handshake;

    // CLOCK only documents the timebase; it drives no logic.
    logic unused_clock_param;
    assign unused_clock_param = ^CLOCK;

    assign state_dbg = state;
    assign handshake = result_valid && result_ready && !abort;

    freq_decision #(
        .MIN_TICKS (MIN_TICKS)
    ) u_decision (
        .f1   (f1_value),
        .f2   (f2_value),
        .code (dec_code)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; abort overrides every transition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = CLEAR;
            CLEAR:    state_next = MEASURE;
            MEASURE:  if (win_cnt == CNT_LAST) state_next = SETTLE;
            SETTLE:   state_next = EVALUATE;
            EVALUATE: state_next = OUTPUT;
            OUTPUT:   if (result_ready) state_next = continuous ? CLEAR : IDLE;
            default:  state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    // Registered outputs decoded from the next state so they line up with it.
    // The comparator only honours clear while enabled, hence enable in CLEAR.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmp_enable   <= 1'b0;
            cmp_clear    <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            cmp_enable   <= (state_next == CLEAR) || (state_next == MEASURE);
            cmp_clear    <= (state_next == CLEAR);
            result_valid <= (state_next == OUTPUT);
            busy         <= (state_next != IDLE);
        end
    end

    // Window counter: zeroed on the way out of CLEAR, counts through MEASURE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_cnt <= '0;
        end else if (state == CLEAR) begin
            win_cnt <= '0;
        end else if (state == MEASURE) begin
            win_cnt <= win_cnt + CNT_W'(1);
        end
    end

    // Capture the frozen accumulators and decision; held until next EVALUATE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_code <= RESULT_NONE;
            result_f1   <= '0;
            result_f2   <= '0;
        end else if ((state == EVALUATE) && !abort) begin
            result_code <= dec_code;
            result_f1   <= f1_value;
            result_f2   <= f2_value;
        end
    end

`ifdef FREQ_WINDOW_STATS_EN
    logic [15:0] stat_f1_q;
    logic [15:0] stat_f2_q;
    logic [15:0] stat_none_q;

    assign stat_f1_count   = stat_f1_q;
    assign stat_f2_count   = stat_f2_q;
    assign stat_none_count = stat_none_q;

    // Saturating per-code counters, stepped on each delivered result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_f1_q   <= '0;
            stat_f2_q   <= '0;
            stat_none_q <= '0;
        end else if (handshake) begin
            if (result_code == RESULT_F1) begin
                if (stat_f1_q != 16'hFFFF) stat_f1_q <= stat_f1_q + 16'd1;
            end else if (result_code == RESULT_F2) begin
                if (stat_f2_q != 16'hFFFF) stat_f2_q <= stat_f2_q + 16'd1;
            end else begin
                if (stat_none_q != 16'hFFFF) stat_none_q <= stat_none_q + 16'd1;
            end
        end
    end
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_frequency_window_controller.sv
// Directed bench for frequency_window_controller with WINDOW_TICKS=100,
// MIN_TICKS=25. Inputs are driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_frequency_window_controller;
    import freq_detect_pkg::*;

    localparam int unsigned WT = 100;
    localparam int unsigned MT = 25;

    logic        clock;
    logic        reset;
    logic        start;
    logic        continuous;
    logic        abort;
    logic        cmp_enable;
    logic        cmp_clear;
    logic [31:0] f1_value;
    logic [31:0] f2_value;
    logic        result_valid;
    logic        result_ready;
    logic [1:0]  result_code;
    logic [31:0] result_f1;
    logic [31:0] result_f2;
    logic        busy;
    state_t      state_dbg;
`ifdef FREQ_WINDOW_STATS_EN
    logic [15:0] stat_f1_count;
    logic [15:0] stat_f2_count;
    logic [15:0] stat_none_count;
`endif

    logic [31:0] ref_f1;
    logic [31:0] ref_f2;
    logic [1:0]  ref_code;

    int checks = 0;
    int errors = 0;

    // Scoreboard of results expected at the handshake.
    logic [1:0]  exp_q[$];
    logic [31:0] exp_f1_q[$];
    logic [31:0] exp_f2_q[$];

    frequency_window_controller #(
        .WINDOW_TICKS (WT),
        .MIN_TICKS    (MT),
        .CLOCK        (50000000)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .continuous   (continuous),
        .abort        (abort),
        .cmp_enable   (cmp_enable),
        .cmp_clear    (cmp_clear),
        .f1_value     (f1_value),
        .f2_value     (f2_value),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_code  (result_code),
        .result_f1    (result_f1),
        .result_f2    (result_f2),
        .busy         (busy),
`ifdef FREQ_WINDOW_STATS_EN
        .stat_f1_count   (stat_f1_count),
        .stat_f2_count   (stat_f2_count),
        .stat_none_count (stat_none_count),
`endif
        .state_dbg    (state_dbg)
    );

    freq_decision #(
        .MIN_TICKS (MT)
    ) u_ref_decision (
        .f1   (ref_f1),
        .f2   (ref_f2),
        .code (ref_code)
    );

    // Clock and watchdog.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    typedef struct {
        logic [31:0] f1;
        logic [31:0] f2;
        logic [1:0]  code;
    } dec_vec_t;

    dec_vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Starts a window from a falling edge and measures enable/clear/latency.
    task automatic run_window(input logic [31:0] f1, input logic [31:0] f2,
                              input logic [1:0] code, input bit poke_start);
        int en_cnt;
        int clr_cnt;
        int lat;
        en_cnt  = 0;
        clr_cnt = 0;
        lat     = -1;
        f1_value = f1;
        f2_value = f2;
        start    = 1'b1;
        exp_q.push_back(code);
        exp_f1_q.push_back(f1);
        exp_f2_q.push_back(f2);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clock);
            start = poke_start && (k == 50);
            if (cmp_enable) en_cnt++;
            if (cmp_clear) clr_cnt++;
            if (result_valid) begin
                lat = k - 1;
                break;
            end
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'(WT + 3));
        check("enable_cycles", 32'(en_cnt), 32'(WT + 1));
        check("clear_cycles", 32'(clr_cnt), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (result_valid) break;
            @(negedge clock);
        end
        if (k == budget) begin
            errors++;
            $display("FAIL wait_valid actual=timeout required=valid");
        end
    endtask

    // Scoreboard compare at the handshake, then one-cycle ready pulse.
    task automatic accept();
        logic [1:0]  ec;
        logic [31:0] e1;
        logic [31:0] e2;
        ec = exp_q.pop_front();
        e1 = exp_f1_q.pop_front();
        e2 = exp_f2_q.pop_front();
        check("valid_at_accept", 32'(result_valid), 32'd1);
        check("result_code", 32'(result_code), 32'(ec));
        check("result_f1", result_f1, e1);
        check("result_f2", result_f2, e2);
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
    endtask

    task automatic drop_expect();
        void'(exp_q.pop_front());
        void'(exp_f1_q.pop_front());
        void'(exp_f2_q.pop_front());
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        abort = 1'b0;
        result_ready = 1'b0;
        f1_value = '0;
        f2_value = '0;
        ref_f1 = '0;
        ref_f2 = '0;

        vecs[0]  = '{32'd60, 32'd10, RESULT_F1};
        vecs[1]  = '{32'd10, 32'd20, RESULT_NONE};
        vecs[2]  = '{32'd40, 32'd40, RESULT_TIE};
        vecs[3]  = '{32'd24, 32'd24, RESULT_NONE};
        vecs[4]  = '{32'd25, 32'd25, RESULT_TIE};
        vecs[5]  = '{32'd24, 32'd25, RESULT_F2};
        vecs[6]  = '{32'd25, 32'd24, RESULT_F1};
        vecs[7]  = '{32'd0,  32'd0,  RESULT_NONE};
        vecs[8]  = '{32'd30, 32'd100, RESULT_F2};
        vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, RESULT_F1};
        vecs[10] = '{32'd24, 32'd0,  RESULT_NONE};
        vecs[11] = '{32'h80000000, 32'd7, RESULT_F1};

        repeat (3) @(negedge clock);
        check("reset_enable", 32'(cmp_enable), 32'd0);
        check("reset_clear", 32'(cmp_clear), 32'd0);
        check("reset_valid", 32'(result_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_code", 32'(result_code), 32'd0);
        check("reset_f1", result_f1, 32'd0);
        check("reset_f2", result_f2, 32'd0);
        check("reset_state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b0;
        @(negedge clock);

        // Decision table against the shared decision block.
        for (int i = 0; i < 12; i++) begin
            ref_f1 = vecs[i].f1;
            ref_f2 = vecs[i].f2;
            #1;
            check($sformatf("decision_vec%0d", i), 32'(ref_code), 32'(vecs[i].code));
        end
        @(negedge clock);

        // Basic window, then ready with nothing valid.
        run_window(32'd60, 32'd10, RESULT_F1, 1'b0);
        accept();
        check("idle_after_accept_valid", 32'(result_valid), 32'd0);
        check("idle_after_accept_busy", 32'(busy), 32'd0);
        result_ready = 1'b1;
        repeat (3) @(negedge clock);
        result_ready = 1'b0;
        check("ready_idle_state", 32'(state_dbg), 32'(IDLE));

        // Start pulsed mid-window must not disturb it.
        run_window(32'd10, 32'd20, RESULT_NONE, 1'b1);
        accept();
        run_window(32'd40, 32'd40, RESULT_TIE, 1'b0);
        accept();

        // Continuous with backpressure, then continuous dropped mid-window.
        continuous = 1'b1;
        run_window(32'd5, 32'd70, RESULT_F2, 1'b0);
        f1_value = 32'd999;
        f2_value = 32'd999;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (result_valid !== 1'b1 || result_code !== RESULT_F2 || result_f1 !== 32'd5 ||
                result_f2 !== 32'd70 || cmp_clear !== 1'b0 || cmp_enable !== 1'b0) bad++;
        end
        check("hold_stable_bad_cycles", 32'(bad), 32'd0);
        accept();
        check("cont_clear_next", 32'(cmp_clear), 32'd1);
        check("cont_state_clear", 32'(state_dbg), 32'(CLEAR));
        continuous = 1'b0;
        exp_q.push_back(RESULT_TIE);
        exp_f1_q.push_back(32'd999);
        exp_f2_q.push_back(32'd999);
        wait_valid(300);
        accept();
        check("cont_drop_idle", 32'(busy), 32'd0);

        // Abort in MEASURE.
        f1_value = 32'd60;
        f2_value = 32'd10;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (40) @(negedge clock);
        check("abort_pre_measure", 32'(state_dbg), 32'(MEASURE));
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_state", 32'(state_dbg), 32'(IDLE));
        check("abort_enable", 32'(cmp_enable), 32'd0);
        check("abort_clear", 32'(cmp_clear), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_retained_f1", result_f1, 32'd999);
        bad = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clock);
            if (result_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("abort_no_valid", 32'(bad), 32'd0);
        run_window(32'd60, 32'd10, RESULT_F1, 1'b0);
        accept();

        // start and abort together.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);

        // Async reset between edges while in OUTPUT.
        run_window(32'd70, 32'd5, RESULT_F1, 1'b0);
        drop_expect();
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", 32'(result_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_code", 32'(result_code), 32'd0);
        check("async_f1", result_f1, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Three F2 results accepted, one aborted in OUTPUT with ready high.
        for (int i = 0; i < 3; i++) begin
            run_window(32'd30 + 32'(i), 32'd90, RESULT_F2, 1'b0);
            accept();
        end
        run_window(32'd26, 32'd80, RESULT_F2, 1'b0);
        drop_expect();
        abort = 1'b1;
        result_ready = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        result_ready = 1'b0;
        check("abort_output_valid", 32'(result_valid), 32'd0);
        check("abort_output_code_kept", 32'(result_code), 32'(RESULT_F2));
`ifdef FREQ_WINDOW_STATS_EN
        check("stat_f2_three", 32'(stat_f2_count), 32'd3);
        check("stat_f1_zero", 32'(stat_f1_count), 32'd0);
        check("stat_none_zero", 32'(stat_none_count), 32'd0);
        force dut.stat_f2_q = 16'hFFFE;
        @(negedge clock);
        release dut.stat_f2_q;
        for (int i = 0; i < 2; i++) begin
            run_window(32'd1, 32'd50, RESULT_F2, 1'b0);
            accept();
        end
        check("stat_f2_saturated", 32'(stat_f2_count), 32'hFFFF);
        check("stat_f1_still_zero", 32'(stat_f1_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
